// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: flit-type encoding and head-field placement.
// Used by the router, the injection packetizer and the ejection stage.
package noc_pkg;

    localparam int FT_W = 2;

    typedef enum logic [FT_W-1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    // Head fields are packed from the MSB down: type, dst_x, dst_y, src_x, src_y, len.
    function automatic int coord_lsb(int fw, int cw, int idx);
        return fw - FT_W - (idx + 1) * cw;
    endfunction

    function automatic int len_lsb(int fw, int cw, int lw);
        return fw - FT_W - 4 * cw - lw;
    endfunction

endpackage

// File: rtl/noc_flit_reg.sv
// Registered valid/ready output slot; loads only when empty or draining.
// Reusable by any injection source feeding a router local port.
module noc_flit_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] q_o,
    output logic         free_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign q_o     = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (free_o) begin
            valid_d = load_i;
            if (load_i) data_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/noc_ni_packetizer.sv
// NI injection stage: request + payload stream -> head/body/tail flits.
// Define NOC_NI_PARITY_EN to put even parity over the head flit in bit 0.
module noc_ni_packetizer
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 64,
    parameter int COORD_W    = 4,
    parameter int LEN_W      = 8,
    parameter int SRC_X      = 0,
    parameter int SRC_Y      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [COORD_W-1:0]    req_dst_x,
    input  logic [COORD_W-1:0]    req_dst_y,
    input  logic [LEN_W-1:0]      req_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [FLIT_WIDTH-3:0] data_in,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  busy,
    output logic [15:0]           pkt_count
);

    localparam int DX_LSB  = coord_lsb(FLIT_WIDTH, COORD_W, 0);
    localparam int DY_LSB  = coord_lsb(FLIT_WIDTH, COORD_W, 1);
    localparam int SX_LSB  = coord_lsb(FLIT_WIDTH, COORD_W, 2);
    localparam int SY_LSB  = coord_lsb(FLIT_WIDTH, COORD_W, 3);
    localparam int LEN_LSB = len_lsb(FLIT_WIDTH, COORD_W, LEN_W);

    typedef enum logic {S_IDLE, S_BODY} state_e;

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    out_free, load;
    logic [FLIT_WIDTH-1:0]   flit_d, head;
    logic [FT_W-1:0]         out_type;

    always_comb begin
        head = '0;
        head[FLIT_WIDTH-1 -: FT_W] = (req_len == '0) ? FT_SINGLE : FT_HEAD;
        head[DX_LSB +: COORD_W]    = req_dst_x;
        head[DY_LSB +: COORD_W]    = req_dst_y;
        head[SX_LSB +: COORD_W]    = COORD_W'(SRC_X);
        head[SY_LSB +: COORD_W]    = COORD_W'(SRC_Y);
        head[LEN_LSB +: LEN_W]     = req_len;
`ifdef NOC_NI_PARITY_EN
        head[0] = ^head[FLIT_WIDTH-1:1];
`else
        head[0] = 1'b0;
`endif
    end

    // rst_n gates req_ready so nothing is accepted while reset is held.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        load       = 1'b0;
        flit_d     = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = out_free && rst_n;
                if (req_valid && req_ready) begin
                    load   = 1'b1;
                    flit_d = head;
                    rem_d  = req_len;
                    if (req_len != '0) state_d = S_BODY;
                end
            end
            S_BODY: begin
                data_ready = out_free;
                if (data_valid && data_ready) begin
                    load  = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        flit_d  = {FT_TAIL, data_in};
                        state_d = S_IDLE;
                    end else begin
                        flit_d = {FT_BODY, data_in};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    noc_flit_reg #(.W(FLIT_WIDTH)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .d_i     (flit_d),
        .ready_i (ready_in),
        .valid_o (valid_out),
        .q_o     (flit_out),
        .free_o  (out_free)
    );

    assign out_type = flit_out[FLIT_WIDTH-1 -: FT_W];

    always_comb begin
        cnt_d = cnt_q;
        if (valid_out && ready_in &&
            (out_type == FT_TAIL || out_type == FT_SINGLE))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != S_IDLE) || valid_out;
    assign pkt_count = cnt_q;

endmodule
